frame_packetizer: RTL and testbench

Parametrised successor to the fixed-format mixed-mode packetizer. It builds one framed packet per input AXIS packet, in this order: preamble, sync word, mode field, length field, guard, payload, then a mandatory idle gap. Field lengths and sync pattern are parameters. The output honours full AXIS backpressure, and the block flags length/tlast mismatches. It sits in the slow-clock TX path between the payload FIFO and the symbol mapper.

---
 rtl/frame_packetizer.sv | 219 +++++++++++++++++++++
 tb/tb_frame_packetizer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_packetizer.sv
`default_nettype none
// ============================================================================
// frame_packetizer : frames each AXIS payload packet with preamble, sync,
//                    mode, length and guard fields, then an idle gap.
// Revision         : 1.0
// ============================================================================
module frame_packetizer #(
    parameter int          DATA_W    = 8,
    parameter int          LEN_W     = 16,
    parameter int          PRE_LEN   = 224,
    parameter int          SYNC_LEN  = 32,
    parameter logic [31:0] SYNC_WORD = 32'hAAAA_AAAA,
    parameter int          GUARD_LEN = 40,
    parameter int          GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bypass,
    input  logic [LEN_W-1:0]  payload_length,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic              in_tlast,
    input  logic              in_tuser,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output logic              out_tuser,
    output logic              hdr_vld,
    output logic              busy,
    output logic              pkt_err
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PRE   = 4'd1,
        S_SYNC  = 4'd2,
        S_MODE  = 4'd3,
        S_LEN   = 4'd4,
        S_GUARD = 4'd5,
        S_PLD   = 4'd6,
        S_FLUSH = 4'd7,
        S_GAP   = 4'd8
    } state_t;

    localparam int c_MODE_LEN = 8;

    state_t             r_state;
    logic [31:0]        r_cnt;
    logic [LEN_W-1:0]   r_plen;
    logic [LEN_W-1:0]   r_pcnt;
    logic               r_is_bpsk;

    logic               w_load;
    logic               w_hdr_bit;
    logic               w_field_last;
    logic               w_pld_last;
    state_t             w_next_hdr;
    logic [LEN_W-1:0]   w_plen_inc;
    logic [LEN_W-1:0]   w_plen;

    assign w_load     = !out_tvalid || out_tready;
    assign w_plen_inc = payload_length + LEN_W'(1);
    assign w_plen     = in_tuser ? payload_length : (w_plen_inc >> 1);
    assign w_pld_last = (r_pcnt == r_plen - LEN_W'(1));
    assign busy       = (r_state != S_IDLE);

    // Header symbol for the current field position, plus field sequencing
    always_comb begin
        w_hdr_bit    = 1'b0;
        w_field_last = 1'b0;
        w_next_hdr   = S_IDLE;
        case (r_state)
            S_PRE: begin
                w_hdr_bit    = r_cnt[0];
                w_field_last = (r_cnt == 32'(PRE_LEN - 1));
                w_next_hdr   = S_SYNC;
            end
            S_SYNC: begin
                w_hdr_bit    = 1'(SYNC_WORD >> (32'(SYNC_LEN - 1) - r_cnt));
                w_field_last = (r_cnt == 32'(SYNC_LEN - 1));
                w_next_hdr   = S_MODE;
            end
            S_MODE: begin
                w_hdr_bit    = r_is_bpsk;
                w_field_last = (r_cnt == 32'(c_MODE_LEN - 1));
                w_next_hdr   = S_LEN;
            end
            S_LEN: begin
                w_hdr_bit    = 1'(r_plen >> (32'(LEN_W - 1) - r_cnt));
                w_field_last = (r_cnt == 32'(LEN_W - 1));
                w_next_hdr   = S_GUARD;
            end
            S_GUARD: begin
                w_hdr_bit    = r_cnt[0];
                w_field_last = (r_cnt == 32'(GUARD_LEN - 1));
                w_next_hdr   = (r_plen == '0) ? S_GAP : S_PLD;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_tready = 1'b0;
        case (r_state)
            S_IDLE:  in_tready = bypass && w_load;
            S_PLD:   in_tready = w_load;
            S_FLUSH: in_tready = 1'b1;
            default: in_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_plen     <= '0;
            r_pcnt     <= '0;
            r_is_bpsk  <= 1'b0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tuser  <= 1'b1;
            hdr_vld    <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bypass) begin
                        if (w_load) begin
                            out_tvalid <= in_tvalid;
                            out_tdata  <= in_tdata;
                            out_tlast  <= in_tlast;
                            out_tuser  <= in_tuser;
                            hdr_vld    <= 1'b0;
                        end
                    end else begin
                        if (w_load) begin
                            out_tvalid <= 1'b0;
                            out_tlast  <= 1'b0;
                            hdr_vld    <= 1'b0;
                        end
                        // The first payload beat stays on the input until PLD
                        if (in_tvalid) begin
                            r_plen    <= w_plen;
                            r_is_bpsk <= in_tuser;
                            r_cnt     <= '0;
                            r_pcnt    <= '0;
                            r_state   <= S_PRE;
                        end
                    end
                end
                S_PRE, S_SYNC, S_MODE, S_LEN, S_GUARD: begin
                    if (w_load) begin
                        out_tvalid <= 1'b1;
                        out_tdata  <= {DATA_W{w_hdr_bit}};
                        out_tuser  <= 1'b1;
                        hdr_vld    <= 1'b1;
                        out_tlast  <= (r_state == S_GUARD) && w_field_last && (r_plen == '0);
                        if (w_field_last) begin
                            r_cnt   <= '0;
                            r_state <= w_next_hdr;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                S_PLD: begin
                    if (w_load) begin
                        if (in_tvalid) begin
                            out_tvalid <= 1'b1;
                            out_tdata  <= in_tdata;
                            out_tuser  <= r_is_bpsk;
                            hdr_vld    <= 1'b0;
                            out_tlast  <= w_pld_last || in_tlast;
                            r_pcnt     <= r_pcnt + LEN_W'(1);
                            if (w_pld_last || in_tlast) begin
                                pkt_err <= w_pld_last ^ in_tlast;
                                r_state <= (w_pld_last && !in_tlast) ? S_FLUSH : S_GAP;
                            end
                        end else begin
                            out_tvalid <= 1'b0;
                            out_tlast  <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_load) begin
                        out_tvalid <= 1'b0;
                        out_tlast  <= 1'b0;
                        hdr_vld    <= 1'b0;
                    end
                    if (in_tvalid && in_tlast) begin
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Counting starts once the tlast beat has left the output stage
                    if (w_load) begin
                        out_tvalid <= 1'b0;
                        out_tlast  <= 1'b0;
                        hdr_vld    <= 1'b0;
                        if (r_cnt == 32'(GAP_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_packetizer.sv
`default_nettype none
// ============================================================================
// tb_frame_packetizer : randomized scoreboard bench for frame_packetizer.
// Revision            : 1.0
// ============================================================================
module tb_frame_packetizer;

    localparam int          DATA_W    = 8;
    localparam int          LEN_W     = 16;
    localparam int          PRE_LEN   = 224;
    localparam int          SYNC_LEN  = 32;
    localparam logic [31:0] SYNC_WORD = 32'hAAAA_AAAA;
    localparam int          GUARD_LEN = 40;
    localparam int          GAP_LEN   = 2;
    localparam int          TMO       = 5000;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       h;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bypass = 1'b0;
    logic [LEN_W-1:0]  payload_length = '0;
    logic [DATA_W-1:0] in_tdata = '0;
    logic              in_tvalid = 1'b0;
    logic              in_tready;
    logic              in_tlast = 1'b0;
    logic              in_tuser = 1'b0;
    logic [DATA_W-1:0] out_tdata;
    logic              out_tvalid;
    logic              out_tready = 1'b1;
    logic              out_tlast;
    logic              out_tuser;
    logic              hdr_vld;
    logic              busy;
    logic              pkt_err;

    int    vectors = 0;
    int    miscompares = 0;
    int    exp_err = 0;
    int    seen_err = 0;
    int    gap_left = 0;
    int    beat_no = 0;
    bit    mon_en = 1'b0;
    bit    rdy_rand = 1'b0;
    bit    hold_pend = 1'b0;
    beat_t held;
    beat_t exp_q[$];

    frame_packetizer #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .PRE_LEN(PRE_LEN), .SYNC_LEN(SYNC_LEN),
        .SYNC_WORD(SYNC_WORD), .GUARD_LEN(GUARD_LEN), .GAP_LEN(GAP_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bypass(bypass), .payload_length(payload_length),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tlast(in_tlast), .in_tuser(in_tuser), .out_tdata(out_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_tuser(out_tuser), .hdr_vld(hdr_vld), .busy(busy), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every accepted output beat
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{d: out_tdata, l: out_tlast, u: out_tuser, h: hdr_vld};
        if (!mon_en) begin
            hold_pend = 1'b0;
            gap_left  = 0;
        end else begin
            if (hold_pend) begin
                vectors++;
                if (cur != held) begin
                    miscompares++;
                    $display("FAIL hold: out changed under backpressure got %h want %h", cur, held);
                end
            end
            hold_pend = out_tvalid && !out_tready;
            held      = cur;
            if (gap_left > 0) begin
                vectors++;
                if (out_tvalid) begin
                    miscompares++;
                    $display("FAIL gap: out_tvalid=%b in idle gap, want 0", out_tvalid);
                end
                gap_left--;
            end
            if (pkt_err) seen_err++;
            if (out_tvalid && out_tready) begin
                beat_no++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat %0d: unexpected beat %h, want none", beat_no, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        miscompares++;
                        $display("FAIL beat %0d: got d=%h l=%b u=%b h=%b want d=%h l=%b u=%b h=%b",
                                 beat_no, cur.d, cur.l, cur.u, cur.h, e.d, e.l, e.u, e.h);
                    end
                end
                if (out_tlast) begin
                    beat_no = 0;
                    if (!bypass) gap_left = GAP_LEN;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_hdr(input bit b, input bit last);
        exp_q.push_back('{d: b ? 8'hFF : 8'h00, l: last, u: 1'b1, h: 1'b1});
    endtask

    // Reference model from the framing rules, then drive the input packet
    task automatic send_pkt(input bit bpsk, input int len, input int nbeats);
        logic [7:0]  pd [0:63];
        logic [31:0] sw;
        int          plen;
        int          t;
        bit          hs;
        sw = SYNC_WORD;
        for (int i = 0; i < nbeats; i++) pd[i] = 8'($urandom_range(0, 255));
        plen = bpsk ? len : (((len + 1) % 65536) / 2);
        for (int i = 0; i < PRE_LEN; i++)   push_hdr(1'(i % 2), 1'b0);
        for (int i = 0; i < SYNC_LEN; i++)  push_hdr(sw[SYNC_LEN-1-i], 1'b0);
        for (int i = 0; i < 8; i++)         push_hdr(bpsk, 1'b0);
        for (int i = 0; i < LEN_W; i++)     push_hdr(1'((plen >> (LEN_W-1-i)) & 1), 1'b0);
        for (int i = 0; i < GUARD_LEN; i++) push_hdr(1'(i % 2), (plen == 0) && (i == GUARD_LEN-1));
        if (plen > 0) begin
            for (int j = 1; j <= nbeats; j++) begin
                bit tl;
                tl = (j == nbeats);
                exp_q.push_back('{d: pd[j-1], l: (j == plen) || tl, u: bpsk, h: 1'b0});
                if ((j == plen) != tl) exp_err++;
                if (j == plen || tl) break;
            end
        end
        payload_length = LEN_W'(len);
        in_tuser       = bpsk;
        if (nbeats == 0) begin
            in_tvalid = 1'b1;
            in_tlast  = 1'b0;
            for (t = 0; t < TMO; t++) begin
                @(posedge clk); #1;
                if (busy) break;
            end
            if (t == TMO) begin
                miscompares++;
                $display("FAIL start: busy=%b, want 1", busy);
            end
            in_tvalid = 1'b0;
        end else begin
            for (int j = 0; j < nbeats; j++) begin
                for (int b = 0; b < 3 && $urandom_range(0, 3) == 0; b++) begin
                    in_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
                in_tdata  = pd[j];
                in_tlast  = (j == nbeats - 1);
                in_tvalid = 1'b1;
                hs = 1'b0;
                for (t = 0; t < TMO && !hs; t++) begin
                    @(negedge clk);
                    hs = in_tready;
                    @(posedge clk); #1;
                end
                if (!hs) begin
                    miscompares++;
                    $display("FAIL in_tready: got %b after %0d cycles, want 1", in_tready, TMO);
                end
            end
            in_tvalid = 1'b0;
            in_tlast  = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && gap_left == 0) break;
        end
        vectors++;
        if (t == TMO) begin
            miscompares++;
            $display("FAIL drain: %0d beats pending busy=%b, want 0 and 0", exp_q.size(), busy);
        end
        check("pkt_err_count", 32'(seen_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_tvalid", 32'(out_tvalid), 0);
        check("rst_out_tdata",  32'(out_tdata), 0);
        check("rst_out_tlast",  32'(out_tlast), 0);
        check("rst_out_tuser",  32'(out_tuser), 1);
        check("rst_hdr_vld",    32'(hdr_vld), 0);
        check("rst_pkt_err",    32'(pkt_err), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_in_tready",  32'(in_tready), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        send_pkt(1'b1, 4, 4);  drain();
        send_pkt(1'b0, 5, 3);  drain();
        rdy_rand = 1'b1;
        send_pkt(1'b1, 4, 4);  drain();
        rdy_rand = 1'b0;
        send_pkt(1'b1, 0, 0);
        send_pkt(1'b1, 2, 2);  drain();
        send_pkt(1'b1, 4, 2);  drain();
        send_pkt(1'b1, 4, 6);  drain();

        rdy_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit bp;
            int len;
            int pl;
            int nb;
            bp  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            pl  = bp ? len : (len + 1) / 2;
            nb  = (pl == 0) ? 0 : $urandom_range((pl > 1) ? pl - 1 : 1, pl + 2);
            send_pkt(bp, len, nb);
            drain();
        end

        // Transparent mode: every beat comes out unchanged
        bypass = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bit hs;
            in_tdata  = 8'($urandom_range(0, 255));
            in_tlast  = (j == 9);
            in_tuser  = 1'($urandom_range(0, 1));
            in_tvalid = 1'b1;
            exp_q.push_back('{d: in_tdata, l: in_tlast, u: in_tuser, h: 1'b0});
            hs = 1'b0;
            for (t = 0; t < TMO && !hs; t++) begin
                @(negedge clk);
                hs = in_tready;
                @(posedge clk); #1;
            end
            if (!hs) begin
                miscompares++;
                $display("FAIL bypass_ready: got %b, want 1", in_tready);
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        drain();
        bypass = 1'b0;

        // Abort mid-payload with a one-cycle reset
        rdy_rand       = 1'b0;
        mon_en         = 1'b0;
        payload_length = 16'd8;
        in_tuser       = 1'b1;
        in_tlast       = 1'b0;
        in_tvalid      = 1'b1;
        for (t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (in_tready) break;
        end
        check("reached_pld", 32'(in_tready), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b0;
        in_tvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_out_tvalid", 32'(out_tvalid), 0);
        check("abort_out_tlast",  32'(out_tlast), 0);
        check("abort_out_tuser",  32'(out_tuser), 1);
        check("abort_hdr_vld",    32'(hdr_vld), 0);
        check("abort_busy",       32'(busy), 0);
        exp_q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;
        send_pkt(1'b1, 3, 3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
